// File: rtl/eth_pkg.sv
// Shared types and helpers for the RX frame FIFO.
package eth_pkg;

  typedef struct packed {
    logic [15:0] ethertype;
    logic [47:0] src_mac;
    logic [15:0] len;
  } eth_meta_t;

  localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RECV = 2'd1,
    W_DROP = 2'd2
  } wr_state_t;

  // Saturating add of a small increment to a 16-bit statistics counter.
  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] d);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, d};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data holds while re is low, so the read register doubles as a pipeline stage.
module eth_sdp_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, enabled so stalled data stays put.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer with destination MAC filter.
// Frames are written speculatively from commit_ptr and only become visible
// (metadata pushed, commit_ptr advanced) once complete; any failure rewinds.
module eth_rx_frame_fifo #(
  parameter int ADDR_W          = 11,
  parameter int META_DEPTH_LOG2 = 3,
  parameter bit ACCEPT_MCAST    = 1'b0
) (
  input  logic        clk125,
  input  logic        rst_n,
  input  logic [47:0] cfg_mac,
  input  logic        cfg_promisc,
  input  logic        frame_start,
  input  logic        frame_last,
  input  logic        frame_abort,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic [47:0] dest_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [15:0] m_ethertype,
  output logic [47:0] m_src_mac,
  output logic [15:0] m_len,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_filt,
  output logic [15:0] stat_drop
);
  import eth_pkg::*;

  localparam int               DEPTH    = 2**META_DEPTH_LOG2;
  localparam logic [ADDR_W-1:0] MAX_FILL = '1;

  // ---------------- write side ----------------
  wr_state_t         st, st_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr;
  logic [15:0]       len, len_n;
  logic [15:0]       hdr_type, hdr_type_n;
  logic [47:0]       hdr_src, hdr_src_n;
  logic              we, push, ovf, own_byte, accept, meta_full_eff;
  logic [ADDR_W-1:0] waddr, free_cur, free_new;
  logic              inc_ok, inc_filt;
  logic [1:0]        inc_drop;
  eth_meta_t         push_meta;

  // ---------------- meta FIFO ----------------
  eth_meta_t                  meta_mem [DEPTH];
  logic [META_DEPTH_LOG2-1:0] m_widx, m_ridx;
  logic [META_DEPTH_LOG2:0]   meta_cnt;
  eth_meta_t                  head;
  logic                       pop;

  // ---------------- read side ----------------
  logic              busy, s1_vld, s1_last, s2_load, s1_free, rd_en, rd_last;
  logic [ADDR_W-1:0] fa;
  logic [15:0]       frem;
  logic [7:0]        ram_q;

  assign accept = cfg_promisc | (dest_mac == cfg_mac) | (dest_mac == MAC_BROADCAST) |
                  (ACCEPT_MCAST & dest_mac[40]);
  assign free_cur = MAX_FILL - (wr_ptr - rd_ptr);
  assign free_new = MAX_FILL - (commit_ptr_n - rd_ptr);
  assign head     = meta_mem[m_ridx];

  // Write FSM: first close out the frame in progress, then handle a new start.
  always_comb begin
    st_n         = st;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    len_n        = len;
    hdr_type_n   = hdr_type;
    hdr_src_n    = hdr_src;
    we           = 1'b0;
    waddr        = wr_ptr;
    push         = 1'b0;
    push_meta    = '{ethertype: hdr_type, src_mac: hdr_src, len: len};
    ovf          = 1'b0;
    inc_ok       = 1'b0;
    inc_filt     = 1'b0;
    inc_drop     = 2'd0;
    // On a start cycle the byte belongs to the new frame unless last closes the old one.
    own_byte     = in_valid & (~frame_start | frame_last);

    unique case (st)
      W_RECV: begin
        if (frame_abort) begin
          wr_ptr_n = commit_ptr;
          inc_drop = 2'd1;
          st_n     = W_IDLE;
        end else begin
          if (own_byte) begin
            if (free_cur != '0) begin
              we       = 1'b1;
              wr_ptr_n = wr_ptr + 1'b1;
              len_n    = len + 16'd1;
            end else begin
              wr_ptr_n = commit_ptr;
              inc_drop = 2'd1;
              ovf      = 1'b1;
              st_n     = frame_last ? W_IDLE : W_DROP;
            end
          end
          if (!ovf) begin
            if (frame_last) begin
              if (len_n == 16'd0) begin
                inc_drop = 2'd1;
              end else begin
                push          = 1'b1;
                push_meta.len = len_n;
                commit_ptr_n  = wr_ptr_n;
                inc_ok        = 1'b1;
              end
              st_n = W_IDLE;
            end else if (frame_start) begin
              // truncated: new start arrived before this frame's last
              wr_ptr_n = commit_ptr;
              inc_drop = 2'd1;
            end
          end
        end
      end
      W_DROP: if (frame_last | frame_abort) st_n = W_IDLE;
      default: ;
    endcase

    // A commit this cycle occupies a meta slot the new frame cannot use.
    meta_full_eff = (int'(meta_cnt) + int'(push)) >= DEPTH;

    if (frame_start) begin
      wr_ptr_n = commit_ptr_n;
      len_n    = 16'd0;
      if (!accept) begin
        st_n     = W_DROP;
        inc_filt = 1'b1;
      end else if (meta_full_eff) begin
        st_n     = W_DROP;
        inc_drop = inc_drop + 2'd1;
      end else begin
        st_n       = W_RECV;
        hdr_type_n = ethertype;
        hdr_src_n  = src_mac;
        if (in_valid && !frame_last) begin
          if (free_new != '0) begin
            we       = 1'b1;
            waddr    = commit_ptr_n;
            wr_ptr_n = commit_ptr_n + 1'b1;
            len_n    = 16'd1;
          end else begin
            inc_drop = inc_drop + 2'd1;
            st_n     = W_DROP;
          end
        end
      end
    end
  end

  // Write-side state, pointers and statistics.
  always_ff @(posedge clk125) begin
    if (!rst_n) begin
      st         <= W_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      len        <= '0;
      hdr_type   <= '0;
      hdr_src    <= '0;
      stat_ok    <= '0;
      stat_filt  <= '0;
      stat_drop  <= '0;
    end else begin
      st         <= st_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      len        <= len_n;
      hdr_type   <= hdr_type_n;
      hdr_src    <= hdr_src_n;
      stat_ok    <= sat_add(stat_ok, {1'b0, inc_ok});
      stat_filt  <= sat_add(stat_filt, {1'b0, inc_filt});
      stat_drop  <= sat_add(stat_drop, inc_drop);
    end
  end

  // Metadata storage: plain registers, no reset needed on the data.
  always_ff @(posedge clk125) begin
    if (push) meta_mem[m_widx] <= push_meta;
  end

  // Metadata FIFO pointers and occupancy.
  always_ff @(posedge clk125) begin
    if (!rst_n) begin
      m_widx   <= '0;
      m_ridx   <= '0;
      meta_cnt <= '0;
    end else begin
      if (push) m_widx <= m_widx + 1'b1;
      if (pop)  m_ridx <= m_ridx + 1'b1;
      unique case ({push, pop})
        2'b10:   meta_cnt <= meta_cnt + 1'b1;
        2'b01:   meta_cnt <= meta_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  eth_sdp_ram #(.ADDR_W(ADDR_W), .DATA_W(8)) u_ram (
    .clk   (clk125),
    .we    (we),
    .waddr (waddr),
    .wdata (in_data),
    .re    (rd_en),
    .raddr (fa),
    .rdata (ram_q)
  );

  // Read pipeline control: RAM register (s1) feeds the output register (s2).
  always_comb begin
    s2_load = ~m_valid | m_ready;
    s1_free = ~s1_vld | s2_load;
    rd_en   = s1_free & (busy ? (frem != 16'd0) : (meta_cnt != '0));
    rd_last = busy ? (frem == 16'd1) : (head.len == 16'd1);
    pop     = m_valid & m_ready & m_last;
  end

  // Read side: fetch head frame, hold metadata until its last beat is taken.
  always_ff @(posedge clk125) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      fa          <= '0;
      frem        <= '0;
      s1_vld      <= 1'b0;
      s1_last     <= 1'b0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      m_ethertype <= '0;
      m_src_mac   <= '0;
      m_len       <= '0;
      rd_ptr      <= '0;
    end else begin
      if (rd_en) begin
        fa   <= fa + 1'b1;
        frem <= (busy ? frem : head.len) - 16'd1;
      end
      if (!busy && meta_cnt != '0) begin
        busy        <= 1'b1;
        m_ethertype <= head.ethertype;
        m_src_mac   <= head.src_mac;
        m_len       <= head.len;
      end else if (pop) begin
        busy <= 1'b0;
      end
      if (rd_en) begin
        s1_vld  <= 1'b1;
        s1_last <= rd_last;
      end else if (s2_load) begin
        s1_vld <= 1'b0;
      end
      if (s2_load) begin
        m_valid <= s1_vld;
        m_last  <= s1_vld & s1_last;
        if (s1_vld) m_data <= ram_q;
      end
      // Space is released only as bytes are accepted downstream.
      if (m_valid & m_ready) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Bench for eth_rx_frame_fifo: two instances (large RAM / 4-entry meta, and a
// 64-byte RAM) share stimulus; a frame-level model predicts each one's output.
module tb_eth_rx_frame_fifo;

  localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER  = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC    = 48'h0A_0B_0C_0D_0E_0F;

  logic        clk125 = 1'b0, rst_n = 1'b0, cfg_promisc = 1'b0;
  logic        frame_start = 1'b0, frame_last = 1'b0, frame_abort = 1'b0;
  logic        in_valid = 1'b0, m_ready = 1'b0;
  logic [47:0] cfg_mac = MY_MAC, dest_mac = '0, src_mac = '0;
  logic [15:0] ethertype = '0;
  logic [7:0]  in_data = '0;

  logic [7:0]  md [2];
  logic        mv [2], ml [2];
  logic [15:0] met [2], mln [2], s_ok [2], s_filt [2], s_drop [2];
  logic [47:0] msrc [2];

  always #4 clk125 = ~clk125;

  eth_rx_frame_fifo #(.ADDR_W(8), .META_DEPTH_LOG2(2), .ACCEPT_MCAST(1'b0)) dut_a (
    .clk125(clk125), .rst_n(rst_n), .cfg_mac(cfg_mac), .cfg_promisc(cfg_promisc),
    .frame_start(frame_start), .frame_last(frame_last), .frame_abort(frame_abort),
    .in_data(in_data), .in_valid(in_valid), .dest_mac(dest_mac), .src_mac(src_mac),
    .ethertype(ethertype), .m_data(md[0]), .m_valid(mv[0]), .m_ready(m_ready),
    .m_last(ml[0]), .m_ethertype(met[0]), .m_src_mac(msrc[0]), .m_len(mln[0]),
    .stat_ok(s_ok[0]), .stat_filt(s_filt[0]), .stat_drop(s_drop[0]));

  eth_rx_frame_fifo #(.ADDR_W(6), .META_DEPTH_LOG2(3), .ACCEPT_MCAST(1'b0)) dut_b (
    .clk125(clk125), .rst_n(rst_n), .cfg_mac(cfg_mac), .cfg_promisc(cfg_promisc),
    .frame_start(frame_start), .frame_last(frame_last), .frame_abort(frame_abort),
    .in_data(in_data), .in_valid(in_valid), .dest_mac(dest_mac), .src_mac(src_mac),
    .ethertype(ethertype), .m_data(md[1]), .m_valid(mv[1]), .m_ready(m_ready),
    .m_last(ml[1]), .m_ethertype(met[1]), .m_src_mac(msrc[1]), .m_len(mln[1]),
    .stat_ok(s_ok[1]), .stat_filt(s_filt[1]), .stat_drop(s_drop[1]));

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic [15:0] ety;
    logic [47:0] src;
    logic [15:0] len;
  } beat_t;

  beat_t      expq [2][$];
  int         total = 0, bad = 0;
  int         m_ok [2], m_filt [2], m_drop [2], beats [2], lasts [2];
  int         cap [2]   = '{255, 63};
  int         depth [2] = '{4, 8};
  logic [7:0] last_byte [2];
  bit         stall [2];
  beat_t      held [2];

  task automatic check_eq(input string nm, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Per-cycle output check against the expected beat queue of instance k.
  task automatic chk(input int k);
    beat_t got, e;
    got = {md[k], ml[k], met[k], msrc[k], mln[k]};
    if (stall[k]) begin
      total++;
      if (!mv[k] || got != held[k]) begin
        bad++;
        $display("FAIL hold%0d got v=%0b %h want %h", k, mv[k], got, held[k]);
      end
    end
    if (mv[k]) begin
      total++;
      if (expq[k].size() == 0) begin
        bad++;
        $display("FAIL extra_beat%0d got %h want none", k, got);
      end else begin
        e = expq[k][0];
        if (got != e) begin
          bad++;
          $display("FAIL beat%0d got %h want %h", k, got, e);
        end
        if (m_ready) begin
          void'(expq[k].pop_front());
          beats[k]++;
          if (ml[k]) lasts[k]++;
          last_byte[k] = md[k];
        end
      end
    end
    stall[k] = mv[k] && !m_ready;
    held[k]  = got;
  endtask

  always @(negedge clk125) begin
    if (rst_n) begin
      chk(0);
      chk(1);
    end else begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end
  end

  // Frame-level model: decide fate at the start from the filter rule, pending
  // frame count and remaining byte capacity; queue the expected beats.
  task automatic model(input int k, input logic [47:0] dst, input logic [15:0] et,
                       input int n, input int base, input bit complete);
    int    pf;
    beat_t b;
    pf = 0;
    for (int i = 0; i < expq[k].size(); i++) if (expq[k][i].last) pf++;
    if (!(cfg_promisc || dst == cfg_mac || dst == BCAST)) m_filt[k]++;
    else if (pf >= depth[k]) m_drop[k]++;
    else if (!complete || n > cap[k] - expq[k].size()) m_drop[k]++;
    else begin
      for (int i = 0; i < n; i++) begin
        b.data = 8'(base + i);
        b.last = (i == n - 1);
        b.ety  = et;
        b.src  = SRC;
        b.len  = 16'(n);
        expq[k].push_back(b);
      end
      m_ok[k]++;
    end
  endtask

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  // mode 0: complete, 1: abort after n bytes, 2: truncated (no last)
  task automatic send(input logic [47:0] dst, input logic [15:0] et, input int n,
                      input int base, input int mode);
    model(0, dst, et, n, base, mode == 0);
    model(1, dst, et, n, base, mode == 0);
    dest_mac = dst; src_mac = SRC; ethertype = et;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid   = 1'b1;
      in_data    = 8'(base + i);
      frame_last = (mode == 0) && (i == n - 1);
      tick();
    end
    in_valid = 1'b0; frame_last = 1'b0;
    if (mode == 1) begin
      frame_abort = 1'b1;
      tick();
      frame_abort = 1'b0;
    end
    tick(); tick();
  endtask

  task automatic wait_drain(input int maxc, input bit rnd);
    int c;
    c = 0;
    while ((expq[0].size() != 0 || expq[1].size() != 0) && c < maxc) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      c++;
    end
    m_ready = 1'b1;
    repeat (4) tick();
    total++;
    if (expq[0].size() != 0 || expq[1].size() != 0) begin
      bad++;
      $display("FAIL drain_timeout left a=%0d b=%0d want 0", expq[0].size(), expq[1].size());
    end
  endtask

  task automatic chk_stats(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s_ok%0d", tag, k), s_ok[k], m_ok[k]);
      check_eq($sformatf("%s_filt%0d", tag, k), s_filt[k], m_filt[k]);
      check_eq($sformatf("%s_drop%0d", tag, k), s_drop[k], m_drop[k]);
    end
  endtask

  initial begin
    int d0, b0, b1, c;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_valid", mv[k], 0);
      check_eq("rst_last", ml[k], 0);
      check_eq("rst_data", md[k], 0);
      check_eq("rst_len", mln[k], 0);
      check_eq("rst_type", met[k], 0);
      check_eq("rst_src", msrc[k], 0);
      check_eq("rst_stats", s_ok[k] + s_filt[k] + s_drop[k], 0);
    end
    rst_n = 1'b1; m_ready = 1'b1;
    tick();

    // 1: unicast to station, 46 bytes
    send(MY_MAC, 16'h0800, 46, 0, 0);
    wait_drain(2000, 1'b0);
    check_eq("t1_beats", beats[0], 46);
    check_eq("t1_lasts", lasts[0], 1);
    check_eq("t1_lastbyte", last_byte[0], 8'h2D);
    check_eq("t1_ok", s_ok[0], 1);
    check_eq("t1_len", mln[0], 46);
    check_eq("t1_type", met[0], 16'h0800);
    chk_stats("t1");

    // 2: filtered, then promiscuous
    send(OTHER, 16'h86DD, 30, 8'h40, 0);
    wait_drain(2000, 1'b0);
    check_eq("t2_filt", s_filt[0], 1);
    check_eq("t2_nobeats", beats[0], 46);
    cfg_promisc = 1'b1;
    send(OTHER, 16'h86DD, 30, 8'h40, 0);
    wait_drain(2000, 1'b0);
    cfg_promisc = 1'b0;
    check_eq("t2_ok", s_ok[0], 2);
    check_eq("t2_beats", beats[0], 76);
    chk_stats("t2");

    // 3: two broadcast frames buffered behind a stalled sink
    m_ready = 1'b0;
    send(BCAST, 16'h0806, 60, 8'h10, 0);
    send(BCAST, 16'h0800, 100, 8'h80, 0);
    repeat (5) tick();
    check_eq("t3_stalled", beats[0], 76);
    wait_drain(2000, 1'b0);
    check_eq("t3_beats", beats[0], 236);
    check_eq("t3_lasts", lasts[0], 4);
    chk_stats("t3");

    // 4: oversize for the small RAM, then a frame that fits
    d0 = s_drop[1]; b1 = beats[1];
    send(BCAST, 16'h0800, 70, 8'h20, 0);
    wait_drain(2000, 1'b0);
    check_eq("t4_drop", s_drop[1], d0 + 1);
    check_eq("t4_none", beats[1], b1);
    send(BCAST, 16'h0800, 20, 8'h55, 0);
    wait_drain(2000, 1'b0);
    check_eq("t4_beats", beats[1], b1 + 20);
    check_eq("t4_lastbyte", last_byte[1], 8'h68);
    chk_stats("t4");

    // 5: aborted frame, truncated frame, then a good one
    d0 = s_drop[0]; b0 = beats[0];
    send(MY_MAC, 16'h0800, 10, 8'h00, 1);
    check_eq("t5_abort", s_drop[0], d0 + 1);
    send(MY_MAC, 16'h0800, 8, 8'h30, 2);
    send(MY_MAC, 16'h0800, 30, 8'h60, 0);
    wait_drain(2000, 1'b0);
    check_eq("t5_drop", s_drop[0], d0 + 2);
    check_eq("t5_beats", beats[0], b0 + 30);
    chk_stats("t5");

    // 6: meta FIFO full, random sink, then reset mid-output
    d0 = s_drop[0]; b0 = beats[0];
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(BCAST, 16'h0800, 20, i * 20, 0);
    check_eq("t6_metafull", s_drop[0], d0 + 1);
    wait_drain(4000, 1'b1);
    check_eq("t6_beats", beats[0], b0 + 80);
    chk_stats("t6");

    m_ready = 1'b0;
    send(BCAST, 16'h0800, 20, 8'hA0, 0);
    c = 0;
    while (!mv[0] && c < 20) begin tick(); c++; end
    check_eq("t6_pending", mv[0], 1);
    rst_n = 1'b0;
    expq[0].delete(); expq[1].delete();
    tick();
    check_eq("t6_rst_va", mv[0], 0);
    check_eq("t6_rst_vb", mv[1], 0);
    for (int k = 0; k < 2; k++) begin
      m_ok[k] = 0; m_filt[k] = 0; m_drop[k] = 0;
    end
    rst_n = 1'b1; m_ready = 1'b1;
    repeat (5) tick();
    check_eq("t6_rst_gone", mv[0], 0);
    chk_stats("t6r");
    b0 = beats[0];
    send(MY_MAC, 16'h0800, 12, 8'h70, 0);
    wait_drain(2000, 1'b0);
    check_eq("t6_after", beats[0], b0 + 12);
    chk_stats("t6a");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
